// File: rtl/program_loader_if.sv
// Byte-stream handshake between the host and the program loader.
// A beat transfers on any rising clock edge where valid and ready are both high.
interface program_loader_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/program_loader.sv
// Program loader for the RISC-SPM memory.
// The loader takes a framed image (LEN, payload, CSUM) from the host stream and
// writes the payload into RAM. The CPU is held in reset for the whole load. It is
// released only when the checksum is good, and from then on its bus is passed
// through to RAM.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_HDR  | waiting for the LEN byte (reset state)
// S_DATA | accepting payload bytes, one registered RAM write per beat
// S_CSUM | waiting for the checksum byte
// S_RUN  | image good, CPU out of reset and owning the memory bus
// S_ERR  | checksum bad, CPU held in reset until reload
module program_loader #(
  parameter int                   DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  program_loader_if.slave      in_bus,
  input  logic                 reload,
  input  logic [DATAWIDTH-1:0] cpu_address,
  input  logic [DATAWIDTH-1:0] cpu_data,
  input  logic                 cpu_write,
  output logic [DATAWIDTH-1:0] mem_address,
  output logic [DATAWIDTH-1:0] mem_data_in,
  output logic                 mem_write,
  output logic                 cpu_clr,
  output logic                 load_done,
  output logic                 load_err
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] sum_q, sum_d;
  logic [DATAWIDTH-1:0] waddr_q, waddr_d;
  logic [DATAWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;
  logic                 wr_pend_q, wr_pend_d;
  logic [DATAWIDTH-1:0] csum_total;
  logic                 ready;
  logic                 beat;

  // State and datapath registers; clr also drops any write still in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_HDR;
      cnt_q     <= '0;
      sum_q     <= '0;
      waddr_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      waddr_q   <= waddr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Next-state, datapath updates and outputs, including the RAM bus mux.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    waddr_d    = waddr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_pend_d  = 1'b0;
    ready      = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    beat       = in_bus.valid && ready;
    csum_total = sum_q + in_bus.data;

    case (state_q)
      S_HDR: begin
        if (beat) begin
          cnt_d   = in_bus.data;
          sum_d   = in_bus.data;
          waddr_d = BASE_ADDR;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          wr_data_d = in_bus.data;
          wr_addr_d = waddr_q;
          wr_pend_d = 1'b1;
          sum_d     = sum_q + in_bus.data;
          waddr_d   = waddr_q + ONE;
          cnt_d     = cnt_q - ONE;
          // LEN = 0 starts the count at zero and wraps, giving a full 2^DATAWIDTH bytes.
          if (cnt_q == ONE) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (beat) state_d = (csum_total == '0) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        if (reload) state_d = S_HDR;
      end
      S_ERR: begin
        if (reload) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    in_bus.ready = ready;
    cpu_clr      = (state_q != S_RUN);
    load_done    = (state_q == S_RUN);
    load_err     = (state_q == S_ERR);

    if (state_q == S_RUN) begin
      mem_address = cpu_address;
      mem_data_in = cpu_data;
      mem_write   = cpu_write;
    end else begin
      mem_address = wr_addr_q;
      mem_data_in = wr_data_q;
      mem_write   = wr_pend_q;
    end
  end

endmodule
